divider_request_arbiter: RTL and testbench
==========================================

// Module: divider_request_arbiter
// PURPOSE
//  Shares one UnsignedIntegerDivision/SignedIntegerDivision core among NUM_REQ requesters.
//  - Round-robin arbitration; one division in flight.
//  - Drives the divider's level handshake (iInputReady / OutputReady) and returns each
//    quotient to its owner with a one-cycle done pulse.
//  - Sits between the shader/ALU issue ports and the single shared fixed-point divider.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  WIDTH          32    operand/quotient width; matches `WIDTH
//  TIMEOUT_CYCLES 255   watchdog limit in WAIT; used only with DIV_ARB_TIMEOUT_EN
// PORTS
//  Clock            in   1              single clock, all logic posedge
//  Reset_n          in   1              synchronous reset, active-low
//  iReq             in   NUM_REQ        level request; held with operands until matching oAck
//  iDividend        in   NUM_REQ*WIDTH  packed; requester k at [k*WIDTH +: WIDTH]
//  iDivisor         in   NUM_REQ*WIDTH  packed, same layout
//  oAck             out  NUM_REQ        one-cycle pulse: operands of requester k latched
//  oDone            out  NUM_REQ        one-cycle pulse: oQuotient valid for requester k
//  oQuotient        out  WIDTH          result register; valid while oDone != 0, held after
//  oBusy            out  1              1 in any state other than IDLE
//  oTimeout         out  1              one-cycle pulse with oDone on watchdog expiry
//  oDivDividend     out  WIDTH          registered operand to divider iDividend
//  oDivDivisor      out  WIDTH          registered operand to divider iDivisor
//  oDivInputReady   out  1              to divider iInputReady
//  iDivQuotient     in   WIDTH          from divider xQuotient
//  iDivOutputReady  in   1              from divider OutputReady
// BEHAVIOUR
//  Reset (Reset_n==0 at posedge): all outputs 0, state IDLE, RR pointer 0, owner 0.
//  - Reset mid-operation abandons the op; no oDone is issued.
//  - The divider is reset from the same net, inverted at the top level.
//  FSM (registered outputs):
//  - IDLE: if |iReq:
//    - owner = first set bit scanning from ptr, ptr+1, ... wrapping mod NUM_REQ
//    - latch owner's operands into oDivDividend/oDivDivisor
//    - oAck[owner]=1 for one cycle; go ISSUE
//  - ISSUE: oDivInputReady<=1; go WAIT.
//  - WAIT: hold oDivInputReady=1.
//    - On iDivOutputReady==1: oQuotient<=iDivQuotient, oDone[owner]<=1 for one cycle,
//      oDivInputReady<=0; go DRAIN.
//  - DRAIN: oDivInputReady=0; when iDivOutputReady==0: ptr<=(owner+1) mod NUM_REQ; go IDLE.
//  Latency and ordering:
//  - iReq to oAck: 1 cycle, when IDLE.
//  - iDivOutputReady to oDone: 1 cycle.
//  - Minimum gap between successive grants: IDLE,ISSUE,WAIT>=1,DRAIN>=1.
//  Handshake rules:
//  - oDivDividend/oDivDivisor are stable from grant until DRAIN exits; the divider
//    samples them in its INITIAL state.
//  - iReq is ignored outside IDLE.
//  - A requester may re-assert iReq after its own oDone; it is arbitrated next IDLE.
//  - The owner's iReq and operands are don't-care after oAck.
//  Boundary cases:
//  - All iReq set: grants rotate 0,1,2,3,0,... with no starvation.
//  - ptr is the wrap point: with ptr=3, NUM_REQ=4 and iReq=4'b1001, the grant is 3,
//    then 0.
//  - Request arriving in the DRAIN->IDLE cycle is seen in the following IDLE cycle.
//  - iDivOutputReady already high on entering WAIT: completion is taken at once (legal).
//  - Divide-by-zero is not special-cased; the divider's 0x0FFFFFFF is passed through.
// CONFIGURATION
//  DIV_ARB_TIMEOUT_EN defined:
//  - An 8..16-bit counter clears on entering WAIT and increments every WAIT cycle.
//  - When it reaches TIMEOUT_CYCLES without iDivOutputReady:
//    - oQuotient<=32'h0FFF_FFFF, oDone[owner]<=1, oTimeout<=1
//    - go DRAIN; DRAIN still waits for iDivOutputReady==0
//  DIV_ARB_TIMEOUT_EN undefined:
//  - WAIT has no bound, no counter is built, oTimeout is tied 0.
// TESTING
//  Testbench pairs this block with SignedIntegerDivision.
//  1 Single req: iReq=4'b0100, Q16.16 operands 0x00060000/0x00020000
//    -> oAck[2] 1 cycle later, oDone[2] with oQuotient=0x00030000, oBusy low after DRAIN.
//  2 Contention: iReq=4'b1111 held; each requester drops iReq on its oAck, re-asserts after
//    its oDone -> grant order 0,1,2,3,0; exactly one oDone bit per completion.
//  3 Wrap: force ptr=3 via prior grant to 2, iReq=4'b1001 -> grant 3 then 0.
//  4 Signed/zero: -6.0/2.0 -> 0xFFFD0000; divisor 0 -> 0x0FFFFFFF passed through.
//  5 Reset_n low for 1 cycle during WAIT -> all outputs 0 next cycle, no oDone.
//    A new req afterwards completes normally.
//  6 DIV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, stub iDivOutputReady=0
//    -> oDone+oTimeout on WAIT cycle 8, oQuotient=0x0FFFFFFF.

Source files
------------

// File: rtl/divider_request_arbiter_if.sv
// Requester-side and divider-side signals of the shared divider arbiter.
// slave = arbiter view, master = environment (requesters + divider) view.
interface divider_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       iReq;
  logic [NUM_REQ*WIDTH-1:0] iDividend;
  logic [NUM_REQ*WIDTH-1:0] iDivisor;
  logic [NUM_REQ-1:0]       oAck;
  logic [NUM_REQ-1:0]       oDone;
  logic [WIDTH-1:0]         oQuotient;
  logic                     oBusy;
  logic                     oTimeout;
  logic [WIDTH-1:0]         oDivDividend;
  logic [WIDTH-1:0]         oDivDivisor;
  logic                     oDivInputReady;
  logic [WIDTH-1:0]         iDivQuotient;
  logic                     iDivOutputReady;

  modport slave (
    input  iReq, iDividend, iDivisor, iDivQuotient, iDivOutputReady,
    output oAck, oDone, oQuotient, oBusy, oTimeout,
           oDivDividend, oDivDivisor, oDivInputReady
  );

  modport master (
    output iReq, iDividend, iDivisor, iDivQuotient, iDivOutputReady,
    input  oAck, oDone, oQuotient, oBusy, oTimeout,
           oDivDividend, oDivDivisor, oDivInputReady
  );
endinterface

// File: rtl/divider_request_arbiter.sv
// Round-robin arbiter sharing one divider among NUM_REQ requesters, one op in flight.
// Optional watchdog on the divider wait: define DIV_ARB_TIMEOUT_EN.
module divider_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  divider_request_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("divider_request_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               irdy_q, irdy_d;
`ifdef DIV_ARB_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // First requester at or after ptr, wrapping.
  logic          found;
  logic [PW-1:0] pick;
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.iReq[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_d   = '0;
    done_d  = '0;
    quot_d  = quot_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    irdy_d  = irdy_q;
`ifdef DIV_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (found) begin
        owner_d     = pick;
        dvd_d       = bus.iDividend[int'(pick)*WIDTH +: WIDTH];
        dvs_d       = bus.iDivisor[int'(pick)*WIDTH +: WIDTH];
        ack_d[pick] = 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: begin
        irdy_d  = 1'b1;
        state_d = WAIT;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.iDivOutputReady) begin
          quot_d          = bus.iDivQuotient;
          done_d[owner_q] = 1'b1;
          irdy_d          = 1'b0;
          state_d         = DRAIN;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        // Divider never answered: return the divider's saturation value.
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          quot_d          = WIDTH'(32'h0FFF_FFFF);
          done_d[owner_q] = 1'b1;
          timeout_d       = 1'b1;
          irdy_d          = 1'b0;
          state_d         = DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DRAIN: begin
        irdy_d = 1'b0;
        // Divider must drop OutputReady before the next op can be issued.
        if (!bus.iDivOutputReady) begin
          ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      quot_q  <= '0;
      busy_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      irdy_q  <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      busy_q  <= busy_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      irdy_q  <= irdy_d;
`ifdef DIV_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.oAck           = ack_q;
  assign bus.oDone          = done_q;
  assign bus.oQuotient      = quot_q;
  assign bus.oBusy          = busy_q;
  assign bus.oDivDividend   = dvd_q;
  assign bus.oDivDivisor    = dvs_q;
  assign bus.oDivInputReady = irdy_q;
`ifdef DIV_ARB_TIMEOUT_EN
  assign bus.oTimeout       = timeout_q;
`else
  assign bus.oTimeout       = 1'b0;
`endif
endmodule

// File: tb/tb_divider_request_arbiter.sv
// Bench for divider_request_arbiter: directed table, hand sequences, and a random
// run against a transaction-level model; a Q16.16 divider stub answers the handshake.
module tb_divider_request_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_request_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  divider_request_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(clk), .Reset_n(rst_n), .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  bit stub_en = 1'b1;
  bit stub_busy = 1'b0;
  int stub_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed Q16.16 quotient; divide-by-zero gives the divider's saturation code.
  function automatic logic [31:0] qdiv(logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    if (b == 0) return 32'h0FFF_FFFF;
    sa = longint'($signed(a)) * 65536;
    sb = longint'($signed(b));
    return 32'(sa / sb);
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic drive_lanes();
    for (int k = 0; k < N; k++) begin
      bus.iDividend[k*W +: W] = opa[k];
      bus.iDivisor[k*W +: W]  = opb[k];
    end
  endtask

  // Divider stub reacts to the arbiter's outputs, then one clock edge passes.
  task automatic cycle();
    if (stub_en) begin
      if (bus.oDivInputReady) begin
        if (!stub_busy) begin
          stub_busy = 1'b1;
          stub_cnt  = $urandom_range(0, 4);
        end else if (stub_cnt > 0) stub_cnt--;
        bus.iDivOutputReady = stub_busy && stub_cnt == 0;
      end else begin
        stub_busy = 1'b0;
        if (bus.iDivOutputReady && $urandom_range(0, 1) == 1) bus.iDivOutputReady = 1'b0;
      end
      bus.iDivQuotient = bus.iDivOutputReady ? qdiv(bus.oDivDividend, bus.oDivDivisor) : $urandom();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ack"},  bus.oAck, 0);
    chk({tag, "_done"}, bus.oDone, 0);
    chk({tag, "_quot"}, bus.oQuotient, 0);
    chk({tag, "_busy"}, bus.oBusy, 0);
    chk({tag, "_tmo"},  bus.oTimeout, 0);
    chk({tag, "_dvd"},  {bus.oDivDividend, bus.oDivDivisor}, 0);
    chk({tag, "_irdy"}, bus.oDivInputReady, 0);
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (bus.oAck != 0) begin idx = onehot_idx(bus.oAck); return; end
    end
    chk("ack_timeout", 1, 0);
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (bus.oDone != 0) begin d = bus.oDone; return; end
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 40 && bus.oBusy; c++) cycle();
    chk("idle_reached", bus.oBusy, 0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [31:0]  a, b;
    int           owner;
    logic [31:0]  q;
  } vec_t;

  initial begin
    vec_t vt [6];
    int idx;
    logic [N-1:0] d;
    // model state for the random run
    bit free, drain;
    int mptr, mo, since;
    logic [31:0] ma, mb, mq;
    logic [N-1:0] r, eack, edone;
    bit ordy;
    bit pend [N];
    bit inflight [N];

    vt[0] = '{4'b0100, 32'h0006_0000, 32'h0002_0000, 2, 32'h0003_0000};
    vt[1] = '{4'b1001, 32'hFFFA_0000, 32'h0002_0000, 3, 32'hFFFD_0000};
    vt[2] = '{4'b1001, 32'h0001_0000, 32'h0000_0000, 0, 32'h0FFF_FFFF};
    vt[3] = '{4'b0011, 32'h0003_0000, 32'h0001_0000, 1, 32'h0003_0000};
    vt[4] = '{4'b0001, 32'h0005_0000, 32'h0005_0000, 0, 32'h0001_0000};
    vt[5] = '{4'b1100, 32'h0001_0000, 32'h0004_0000, 2, 32'h0000_4000};

    bus.iReq = '0; bus.iDividend = '0; bus.iDivisor = '0;
    bus.iDivQuotient = '0; bus.iDivOutputReady = 1'b0;
    for (int k = 0; k < N; k++) begin opa[k] = '0; opb[k] = '0; end

    rst_n = 1'b0;
    cycle(); cycle();
    check_zero("reset");
    rst_n = 1'b1;

    // Directed table: single, wrap at ptr=3, signed, divide-by-zero.
    for (int t = 0; t < 6; t++) begin
      wait_idle();
      for (int k = 0; k < N; k++) begin opa[k] = vt[t].a; opb[k] = vt[t].b; end
      drive_lanes();
      bus.iReq = vt[t].req;
      cycle();
      chk($sformatf("vec%0d_ack", t), bus.oAck, N'(1) << vt[t].owner);
      chk($sformatf("vec%0d_ops", t), {bus.oDivDividend, bus.oDivDivisor}, {vt[t].a, vt[t].b});
      chk($sformatf("vec%0d_busy", t), bus.oBusy, 1);
      bus.iReq = '0;
      wait_done(d);
      chk($sformatf("vec%0d_done", t), d, N'(1) << vt[t].owner);
      chk($sformatf("vec%0d_quot", t), bus.oQuotient, vt[t].q);
      cycle();
      chk($sformatf("vec%0d_done_pulse", t), bus.oDone, 0);
      chk($sformatf("vec%0d_quot_hold", t), bus.oQuotient, vt[t].q);
    end
    wait_idle();

    // Reset while waiting on the divider: op abandoned, no done.
    opa[0] = 32'h0004_0000; opb[0] = 32'h0002_0000; drive_lanes();
    bus.iReq = 4'b0001;
    cycle();
    bus.iReq = '0;
    stub_en = 1'b0; bus.iDivOutputReady = 1'b0;
    cycle(); cycle(); cycle();
    chk("wait_irdy", bus.oDivInputReady, 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_zero("midreset");
    stub_en = 1'b1; stub_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("midreset_no_done", bus.oDone, 0);
    end

    // Contention: all request, each drops on ack and re-raises after done.
    for (int k = 0; k < N; k++) begin opa[k] = W'(k + 1) << 16; opb[k] = 32'h0001_0000; end
    drive_lanes();
    bus.iReq = '1;
    for (int g = 0; g < 5; g++) begin
      wait_ack(idx);
      chk($sformatf("rr_grant%0d", g), idx, g % N);
      if (idx < 0) break;
      bus.iReq[idx] = 1'b0;
      wait_done(d);
      chk($sformatf("rr_done%0d", g), d, N'(1) << idx);
      chk($sformatf("rr_quot%0d", g), bus.oQuotient, W'(idx + 1) << 16);
      bus.iReq[idx] = 1'b1;
    end
    bus.iReq = '0;
    wait_idle();

`ifdef DIV_ARB_TIMEOUT_EN
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    stub_en = 1'b0; bus.iDivOutputReady = 1'b0;
    opa[0] = 32'h0001_0000; opb[0] = 32'h0001_0000; drive_lanes();
    bus.iReq = 4'b0001;
    cycle();
    chk("tmo_ack", bus.oAck, 4'b0001);
    bus.iReq = '0;
    cycle();
    for (int w = 1; w <= TO; w++) begin
      cycle();
      if (w < TO) chk($sformatf("tmo_wait%0d", w), {bus.oDone, bus.oTimeout}, 0);
    end
    chk("tmo_done", {bus.oDone, bus.oTimeout}, {4'b0001, 1'b1});
    chk("tmo_quot", bus.oQuotient, 32'h0FFF_FFFF);
    cycle();
    chk("tmo_pulse", bus.oTimeout, 0);
    chk("tmo_idle", bus.oBusy, 0);
    stub_en = 1'b1; stub_busy = 1'b0;
`endif

    // Random run against a transaction-level model.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check_zero("rand_reset");
    free = 1'b1; drain = 1'b0; mptr = 0; mo = 0; since = 0;
    ma = '0; mb = '0; mq = '0;
    for (int k = 0; k < N; k++) begin pend[k] = 1'b0; inflight[k] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && !inflight[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          opa[k]  = $urandom();
          opb[k]  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
        end
        bus.iReq[k] = pend[k];
      end
      drive_lanes();
      r = bus.iReq;
      cycle();
      ordy = bus.iDivOutputReady;
      eack = '0; edone = '0;
      if (free) begin
        if (r != 0) begin
          mo = rr_pick(r, mptr);
          eack[mo] = 1'b1;
          ma = opa[mo]; mb = opb[mo];
          free = 1'b0; since = 0;
        end
      end else if (!drain) begin
        since++;
        if (since >= 2 && ordy) begin
          edone[mo] = 1'b1;
          mq = qdiv(ma, mb);
          drain = 1'b1;
        end
      end else if (!ordy) begin
        free = 1'b1; drain = 1'b0;
        mptr = (mo + 1) % N;
      end
      chk("rand_ack", bus.oAck, eack);
      chk("rand_done", bus.oDone, edone);
      chk("rand_quot", bus.oQuotient, mq);
      chk("rand_busy", bus.oBusy, !free);
      chk("rand_irdy", bus.oDivInputReady, !free && !drain && since >= 1);
      chk("rand_tmo", bus.oTimeout, 0);
      if (!free) chk("rand_ops", {bus.oDivDividend, bus.oDivDivisor}, {ma, mb});
      for (int k = 0; k < N; k++) begin
        if (bus.oAck[k]) begin pend[k] = 1'b0; inflight[k] = 1'b1; end
        if (bus.oDone[k]) inflight[k] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
